// File: rtl/pg_load_monitor_pkg.sv
// rtl/pg_load_monitor_pkg.sv - shared power-gating constants and FSM state encoding
//
// Purpose: single home for the PG block defaults (epoch length, load width,
//          idle threshold, arming and holdoff epoch counts) and the load
//          monitor state encoding, so every PG block agrees on them.
// Ports:   none (package).
package pg_load_monitor_pkg;

    localparam int PG_EPOCH_LEN      = 64;
    localparam int PG_LOAD_W         = 6;
    localparam int PG_LOAD_THRESH    = 4;
    localparam int PG_IDLE_EPOCHS    = 2;
    localparam int PG_HOLDOFF_EPOCHS = 4;

    typedef enum logic [1:0] {
        PG_MONITOR = 2'd0,
        PG_ARMED   = 2'd1,
        PG_HOLDOFF = 2'd2
    } pg_state_e;

endpackage

// File: rtl/pg_load_monitor_if.sv
// rtl/pg_load_monitor_if.sv - traffic/status bundle between port logic and the load monitor
//
// Purpose: groups the monitored-port signals and the monitor results.
// Signals: flitValid  - a flit crosses the monitored port this cycle
//          portActive - downstream PG FSM reports the port ACTIVE
//          portLoad   - flit count of the last completed epoch
//          pgEnable   - power gating permitted (level)
//          epochDone  - one-cycle pulse after each epoch close
// Modports: master drives traffic/status and observes results;
//           slave is the monitor itself.
interface pg_load_monitor_if
    import pg_load_monitor_pkg::*;
#(
    parameter int LOAD_W = PG_LOAD_W
);
    logic              flitValid;
    logic              portActive;
    logic [LOAD_W-1:0] portLoad;
    logic              pgEnable;
    logic              epochDone;

    modport master (
        output flitValid, portActive,
        input  portLoad, pgEnable, epochDone
    );

    modport slave (
        input  flitValid, portActive,
        output portLoad, pgEnable, epochDone
    );
endinterface

// File: rtl/pg_epoch_timer.sv
// rtl/pg_epoch_timer.sv - free-running epoch counter with close indication
//
// Purpose: counts 0..EPOCH_LEN-1 and wraps; epochEnd is high during the
//          cycle in which the counter holds EPOCH_LEN-1 (the closing cycle).
// Ports:   clk      - clock, rising edge
//          reset    - synchronous active-high, restarts a full epoch
//          epochEnd - closing-cycle indication (decoded from the register)
module pg_epoch_timer
    import pg_load_monitor_pkg::*;
#(
    parameter int EPOCH_LEN = PG_EPOCH_LEN
) (
    input  logic clk,
    input  logic reset,
    output logic epochEnd
);
    localparam int CW = $clog2(EPOCH_LEN);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign epochEnd = (cnt_q == CW'(EPOCH_LEN - 1));

    always_comb begin
        cnt_d = epochEnd ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pg_load_monitor.sv
// rtl/pg_load_monitor.sv - per-port load monitor that arms power gating after idle epochs
//
// Purpose: counts flits per epoch (saturating), publishes the count at each
//          epoch close, and runs a MONITOR/ARMED/HOLDOFF FSM that permits
//          power gating after IDLE_EPOCHS idle epochs and suppresses it for
//          HOLDOFF_EPOCHS epochs after the port wakes up.
// Ports:   clk   - clock, rising edge
//          reset - synchronous active-high
//          mon   - pg_load_monitor_if.slave (flitValid, portActive in;
//                  portLoad, pgEnable, epochDone out, all registered)
module pg_load_monitor
    import pg_load_monitor_pkg::*;
#(
    parameter int EPOCH_LEN      = PG_EPOCH_LEN,
    parameter int LOAD_W         = PG_LOAD_W,
    parameter int LOAD_THRESH    = PG_LOAD_THRESH,
    parameter int IDLE_EPOCHS    = PG_IDLE_EPOCHS,
    parameter int HOLDOFF_EPOCHS = PG_HOLDOFF_EPOCHS
) (
    input  logic               clk,
    input  logic               reset,
    pg_load_monitor_if.slave   mon
);
    localparam int SW = $clog2(IDLE_EPOCHS + 1);
    localparam int HW = $clog2(HOLDOFF_EPOCHS + 1);

    logic              epoch_end;
    logic [LOAD_W-1:0] acc_q, acc_d;
    logic [LOAD_W-1:0] load_q, load_d;
    logic [LOAD_W-1:0] load_now;
    logic              done_q;
    logic              pg_q;
    logic              active_q;
    logic              wake;
    logic              is_idle;
    pg_state_e         state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [HW-1:0]     hold_q, hold_d;

    pg_epoch_timer #(
        .EPOCH_LEN (EPOCH_LEN)
    ) u_epoch_timer (
        .clk      (clk),
        .reset    (reset),
        .epochEnd (epoch_end)
    );

    always_comb begin
        // Running count including this cycle's flit; sticks at all-ones.
        load_now = acc_q;
        if (mon.flitValid && (acc_q != '1)) begin
            load_now = acc_q + LOAD_W'(1);
        end
        is_idle = (load_now < LOAD_W'(LOAD_THRESH));
        wake    = mon.portActive & ~active_q;
        acc_d   = epoch_end ? '0 : load_now;
        load_d  = epoch_end ? load_now : load_q;
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        hold_d   = hold_q;
        unique case (state_q)
            PG_MONITOR: begin
                if (epoch_end) begin
                    if (!is_idle) begin
                        streak_d = '0;
                    end else if (streak_q + SW'(1) >= SW'(IDLE_EPOCHS)) begin
                        state_d  = PG_ARMED;
                        streak_d = '0;
                    end else begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end
            PG_ARMED: begin
                // Wake beats a coincident busy epoch close.
                if (wake) begin
                    state_d = PG_HOLDOFF;
                    hold_d  = HW'(HOLDOFF_EPOCHS);
                end else if (epoch_end && !is_idle) begin
                    state_d  = PG_MONITOR;
                    streak_d = '0;
                end
            end
            PG_HOLDOFF: begin
                if (epoch_end) begin
                    if (hold_q <= HW'(1)) begin
                        hold_d   = '0;
                        state_d  = PG_MONITOR;
                        streak_d = '0;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            default: begin
                state_d  = PG_MONITOR;
                streak_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            load_q   <= '0;
            done_q   <= 1'b0;
            pg_q     <= 1'b0;
            // Starts high so a port already ACTIVE out of reset is not a wake.
            active_q <= 1'b1;
            state_q  <= PG_MONITOR;
            streak_q <= '0;
            hold_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            load_q   <= load_d;
            done_q   <= epoch_end;
            // Follows the registered state, so it moves one clock after the FSM.
            pg_q     <= (state_q == PG_ARMED);
            active_q <= mon.portActive;
            state_q  <= state_d;
            streak_q <= streak_d;
            hold_q   <= hold_d;
        end
    end

    assign mon.portLoad  = load_q;
    assign mon.pgEnable  = pg_q;
    assign mon.epochDone = done_q;
endmodule

// File: tb/tb_pg_load_monitor.sv
// tb/tb_pg_load_monitor.sv - directed self-checking bench for pg_load_monitor
module tb_pg_load_monitor;
    import pg_load_monitor_pkg::*;

    logic clk;
    logic reset;

    pg_load_monitor_if #(.LOAD_W(PG_LOAD_W)) bus ();

    pg_load_monitor dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations taken inside run_epoch for the caller to check.
    int ed1, pg1, pl1, pg_mid;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are applied at a negedge and take effect at the next posedge.
    task automatic drive_cycle(input logic flit, input logic act);
        bus.flitValid  = flit;
        bus.portActive = act;
        @(negedge clk);
    endtask

    // One full 64-cycle epoch: nflit flits from cycle 'start', portActive
    // pulsed high for cycle 'wake_at' (-1 for none).
    task automatic run_epoch(input int nflit, input int start, input int wake_at);
        for (int i = 0; i < 64; i++) begin
            drive_cycle((i >= start) && (i < start + nflit), (i == wake_at));
            if (i == 0) begin
                ed1 = int'(bus.epochDone);
                pg1 = int'(bus.pgEnable);
                pl1 = int'(bus.portLoad);
            end
            if (i == 20) pg_mid = int'(bus.pgEnable);
        end
    endtask

    initial begin
        int seen;
        reset          = 1'b1;
        bus.flitValid  = 1'b0;
        bus.portActive = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_portLoad", int'(bus.portLoad), 0);
        chk("reset_pgEnable", int'(bus.pgEnable), 0);
        chk("reset_epochDone", int'(bus.epochDone), 0);
        reset = 1'b0;

        // E1: stuck-at-1 traffic saturates at 63.
        run_epoch(64, 0, -1);
        chk("e1_portLoad_sat", int'(bus.portLoad), 63);
        chk("e1_epochDone", int'(bus.epochDone), 1);
        chk("e1_pgEnable", int'(bus.pgEnable), 0);

        // E2, E3: idle, arm after second close.
        run_epoch(0, 0, -1);
        chk("e2_epochDone_pulse", ed1, 0);
        chk("e2_portLoad_held", pl1, 63);
        chk("e2_portLoad", int'(bus.portLoad), 0);
        chk("e2_pgEnable", int'(bus.pgEnable), 0);
        run_epoch(0, 0, -1);
        chk("e3_pgEnable_lag", int'(bus.pgEnable), 0);

        // E4: 10 flits, disarm.
        run_epoch(10, 5, -1);
        chk("e4_pgEnable_rise", pg1, 1);
        chk("e4_portLoad", int'(bus.portLoad), 10);
        chk("e4_pgEnable_at_close", int'(bus.pgEnable), 1);

        // E5: idle; E6: flit on last cycle only; E7: flit on cycle 0 only.
        run_epoch(0, 0, -1);
        chk("e5_pgEnable_drop", pg1, 0);
        chk("e5_pgEnable", int'(bus.pgEnable), 0);
        run_epoch(1, 63, -1);
        chk("e6_portLoad_last_cycle", int'(bus.portLoad), 1);
        run_epoch(1, 0, -1);
        chk("e7_pgEnable_armed", pg1, 1);
        chk("e7_portLoad_first_cycle", int'(bus.portLoad), 1);
        chk("e7_pgEnable_mid", pg_mid, 1);

        // E8..E11: wake in ARMED -> four closes of holdoff (wake in E9 ignored).
        run_epoch(0, 0, 10);
        chk("e8_pgEnable_mid_holdoff", pg_mid, 0);
        chk("e8_pgEnable_close", int'(bus.pgEnable), 0);
        run_epoch(0, 0, 3);
        chk("e9_pgEnable_close", int'(bus.pgEnable), 0);
        run_epoch(0, 0, -1);
        chk("e10_pgEnable_close", int'(bus.pgEnable), 0);
        run_epoch(0, 0, -1);
        chk("e11_pgEnable_close", int'(bus.pgEnable), 0);
        // E12, E13: re-arm after two more idle epochs.
        run_epoch(0, 0, -1);
        chk("e12_pgEnable", pg1, 0);
        run_epoch(0, 0, -1);
        chk("e13_pgEnable", pg1, 0);

        // E14: ARMED, busy epoch with wake on the closing cycle -> HOLDOFF.
        run_epoch(10, 5, 63);
        chk("e14_pgEnable_rearmed", pg1, 1);
        chk("e14_portLoad", int'(bus.portLoad), 10);
        run_epoch(0, 0, -1);
        chk("e15_pgEnable", pg1, 0);
        run_epoch(0, 0, -1);
        run_epoch(7, 20, -1);
        chk("e17_still_holdoff", pg1, 0);
        chk("e17_portLoad", int'(bus.portLoad), 7);

        // Reset at cycle 30 with 20 flits counted, flit and wake present too.
        for (int i = 0; i < 30; i++) drive_cycle(i < 20, 1'b0);
        reset = 1'b1;
        drive_cycle(1'b1, 1'b1);
        chk("mid_reset_portLoad", int'(bus.portLoad), 0);
        chk("mid_reset_pgEnable", int'(bus.pgEnable), 0);
        chk("mid_reset_epochDone", int'(bus.epochDone), 0);
        reset = 1'b0;

        // First epoch after reset is a full 64 cycles; partial count discarded.
        seen = 0;
        for (int i = 1; i <= 100; i++) begin
            drive_cycle(i <= 3, 1'b0);
            if (bus.epochDone && seen == 0) seen = i;
            if (seen != 0) break;
        end
        chk("post_reset_epoch_len", seen, 64);
        chk("post_reset_portLoad", int'(bus.portLoad), 3);
        chk("post_reset_pgEnable", int'(bus.pgEnable), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pg_load_monitor.md
PG_LOAD_MONITOR -- requirements
Module: pg_load_monitor

Interface
REQ-001 SHALL have parameter EPOCH_LEN, default 64: epoch length in clk cycles, minimum 2.
REQ-002 SHALL have parameter LOAD_W, default 6: width of portLoad, equal to the shared PG port-load size.
REQ-003 SHALL have parameter LOAD_THRESH, default 4: an epoch with load below this value is idle.
REQ-004 SHALL have parameter IDLE_EPOCHS, default 2: consecutive idle epochs required before arming power gating.
REQ-005 SHALL have parameter HOLDOFF_EPOCHS, default 4: epochs pgEnable is suppressed after a wake-up.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port flitValid, input, 1 bit: a flit traverses the monitored port this cycle.
REQ-009 SHALL have port portActive, input, 1 bit: the downstream power-gating FSM reports the port ACTIVE.
REQ-010 SHALL have port portLoad, output, LOAD_W bits: flit count of the last completed epoch, registered.
REQ-011 SHALL have port pgEnable, output, 1 bit: power gating permitted, registered level.
REQ-012 SHALL have port epochDone, output, 1 bit: one-cycle pulse, high in the cycle after an epoch closes.

Function
REQ-013 SHALL run an epoch counter 0..EPOCH_LEN-1 that wraps to 0; the epoch closes in the cycle where the counter equals EPOCH_LEN-1.
REQ-014 SHALL count flitValid into a LOAD_W-bit accumulator that saturates at 2^LOAD_W-1 and never wraps.
REQ-015 SHALL include a flit in the closing cycle in the closing epoch; at that clock edge portLoad gets the accumulator value plus that flit (saturated), the accumulator clears to 0, and epochDone goes high for one cycle.
REQ-016 SHALL hold portLoad constant between epoch closes.
REQ-017 SHALL implement a 3-state FSM: MONITOR, ARMED, HOLDOFF; pgEnable is 1 only in ARMED.
REQ-018 MONITOR: at epoch close with final count < LOAD_THRESH, increment idleStreak; otherwise clear it. When the incremented value reaches IDLE_EPOCHS, go to ARMED and clear idleStreak.
REQ-019 ARMED: at epoch close with final count >= LOAD_THRESH, go to MONITOR with idleStreak 0.
REQ-020 SHALL register portActive and detect a wake event as portActive 1 this cycle with the registered value 0.
REQ-021 ARMED: a wake event goes to HOLDOFF and loads holdCnt with HOLDOFF_EPOCHS; a wake event in the same cycle as an epoch close also goes to HOLDOFF (wake wins).
REQ-022 HOLDOFF: decrement holdCnt at each epoch close; at the close where holdCnt reaches 0, go to MONITOR with idleStreak 0. Wake events in HOLDOFF are ignored.
REQ-023 SHALL ignore wake events in MONITOR.
REQ-024 SHALL keep portLoad and epochDone updating in every FSM state.
REQ-025 SHALL change pgEnable exactly one clock after the FSM transition that causes it, with no combinational path from inputs.

Reset
REQ-026 reset SHALL set, at the clock edge: epoch counter 0, accumulator 0, portLoad 0, pgEnable 0, epochDone 0, state MONITOR, idleStreak 0, holdCnt 0, registered portActive 1.
REQ-027 reset in the middle of an epoch SHALL discard the partial count, and the first epoch after reset SHALL be a full EPOCH_LEN cycles.
REQ-028 reset SHALL take priority over flitValid, epoch close and wake events in the same cycle.

Structure
REQ-029 EPOCH_LEN, LOAD_THRESH, IDLE_EPOCHS, HOLDOFF_EPOCHS defaults, LOAD_W and the FSM state encodings SHALL be defined in the shared global constants file used by the PG blocks.
REQ-030 The epoch counter and close pulse SHALL be a sub-module pg_epoch_timer (parameter EPOCH_LEN; ports clk, reset, epochEnd).
REQ-031 portLoad SHALL drive the power-gating FSM's port-load input, and pgEnable SHALL drive its gating-enable input.

Verification
REQ-032 EPOCH_LEN=64; flitValid stuck 1 for 64 cycles -> portLoad=63 (saturated), pgEnable stays 0.
REQ-033 Idle traffic: 2 epochs of 0 flits -> pgEnable rises 1 cycle after the 2nd close; a following epoch of 10 flits -> pgEnable drops after that close.
REQ-034 In ARMED, pulse portActive 0->1 -> HOLDOFF; pgEnable 0 for 4 full epoch closes even with 0 traffic; re-arms only after 2 more idle epochs.
REQ-035 Flit only on cycle 63 of an epoch -> portLoad=1 after that close; flit on cycle 0 of the next epoch counts in the next epoch.
REQ-036 Wake event coinciding with epoch close in ARMED -> HOLDOFF, not MONITOR; reset asserted at cycle 30 with 20 flits counted -> all outputs 0, and the next epochDone comes 64 cycles after reset deasserts.
